// File: rtl/lcd_bus_monitor.sv
// lcd_bus_monitor
//    Passive monitor for an HD44780-style LCD bus driven in 4-bit mode.
//    It follows the 8-bit wake-up sequence (three 0x3 commands and then
//    0x2). Once 4-bit mode is entered, it joins each pair of strobed
//    nibbles into one byte. It also flags sequence errors and timing
//    errors: a gap that is too short, or an E pulse that is too narrow.
//
// Parameters
//    FREQ        system clock frequency in Hz (timing limits scale from T1US)
//    T_EH        minimum LCD_E high width in CLK cycles
//
// Ports
//    CLK         system clock, rising edge
//    RST         synchronous active-high reset
//    LCD_D[4:0]  observed bus: bit4 = RS, bits[3:0] = D7..D4
//    LCD_E       observed enable strobe
//    byte_out    last reassembled byte
//    byte_rs     RS of last reassembled byte
//    byte_valid  one-cycle pulse when byte_out/byte_rs update
//    init_done   level, set once 4-bit mode has been entered
//    seq_err     one-cycle pulse on an illegal nibble or RS mismatch
//    timing_err  one-cycle pulse on a gap or E-width violation
//    err_count   saturating count of seq_err plus timing_err events
module lcd_bus_monitor #(
   parameter int FREQ = 50000000,
   parameter int T_EH = 12
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [4:0] LCD_D,
   input  logic       LCD_E,
   output logic [7:0] byte_out,
   output logic       byte_rs,
   output logic       byte_valid,
   output logic       init_done,
   output logic       seq_err,
   output logic       timing_err,
   output logic [7:0] err_count
);

   localparam int T1US = FREQ / 1000000;
   localparam logic [20:0] GAP_INIT_A = 21'(4100 * T1US);
   localparam logic [20:0] GAP_CMD    = 21'(100 * T1US);
   localparam logic [20:0] GAP_NIB    = 21'(1 * T1US);
   localparam logic [20:0] GAP_SLOW   = 21'(1520 * T1US);
   localparam logic [20:0] GAP_FAST   = 21'(37 * T1US);

   typedef enum logic [2:0] {
      INIT_A = 3'd0,
      INIT_B = 3'd1,
      INIT_C = 3'd2,
      INIT_D = 3'd3,
      NIB_HI = 3'd4,
      NIB_LO = 3'd5
   } state_t;

   // Clear display (0x01) and return home (0x02/0x03) are the slow commands
   function automatic logic isSlowCmd(input logic rs, input logic [7:0] b);
      return (rs == 1'b0) && ((b == 8'h01) || (b == 8'h02) || (b == 8'h03));
   endfunction

   // Error counter add that sticks at 8'hFF
   function automatic logic [7:0] satAdd(input logic [7:0] cnt, input logic [1:0] inc);
      logic [8:0] sum;
      sum = {1'b0, cnt} + {7'd0, inc};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

   logic        eQ_r;
   logic [4:0]  dQ_r;
   logic [15:0] eHigh_r;
   logic [20:0] gap_r;
   state_t      state_r;
   state_t      stateNext_s;
   logic [3:0]  hiNib_r;
   logic        hiRs_r;

   logic        strobe_s;
   logic [16:0] eHighNext_s;
   logic        eShort_s;
   logic        timErr_s;
   logic        seqErr_s;
   logic        byteLoad_s;
   logic        hiLoad_s;
   logic        initSet_s;
   logic [20:0] gapLoad_s;
   logic [7:0]  formed_s;

   // A strobe is the falling edge of E as seen through the input register
   assign strobe_s    = eQ_r & ~LCD_E;
   // The count includes the current (last) high cycle of the pulse
   assign eHighNext_s = {1'b0, eHigh_r} + 17'd1;
   assign eShort_s    = eHighNext_s < 17'(T_EH);
   assign timErr_s    = strobe_s & ((gap_r != 21'd0) | eShort_s);
   assign formed_s    = {hiNib_r, dQ_r[3:0]};

   // Single register stage on the observed bus
   always_ff @(posedge CLK) begin
      if (RST) begin
         eQ_r <= 1'b0;
         dQ_r <= 5'd0;
      end else begin
         eQ_r <= LCD_E;
         dQ_r <= LCD_D;
      end
   end

   // Count E-high cycles; cleared on the first cycle after E drops
   always_ff @(posedge CLK) begin
      if (RST) begin
         eHigh_r <= 16'd0;
      end else if (!eQ_r) begin
         eHigh_r <= 16'd0;
      end else if (eHigh_r != 16'hFFFF) begin
         eHigh_r <= eHigh_r + 16'd1;
      end else begin
         eHigh_r <= eHigh_r;
      end
   end

   // Minimum-gap counter: reloaded on every strobe, then runs down to zero
   always_ff @(posedge CLK) begin
      if (RST) begin
         gap_r <= 21'd0;
      end else if (strobe_s) begin
         gap_r <= gapLoad_s;
      end else if (gap_r != 21'd0) begin
         gap_r <= gap_r - 21'd1;
      end else begin
         gap_r <= gap_r;
      end
   end

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= INIT_A;
      end else begin
         state_r <= stateNext_s;
      end
   end

   // FSM next-state logic; any bad init nibble restarts the wake-up sequence
   always_comb begin
      stateNext_s = state_r;
      if (strobe_s) begin
         case (state_r)
            INIT_A:  stateNext_s = (dQ_r == 5'b00011) ? INIT_B : INIT_A;
            INIT_B:  stateNext_s = (dQ_r == 5'b00011) ? INIT_C : INIT_A;
            INIT_C:  stateNext_s = (dQ_r == 5'b00011) ? INIT_D : INIT_A;
            INIT_D:  stateNext_s = (dQ_r == 5'b00010) ? NIB_HI : INIT_A;
            NIB_HI:  stateNext_s = NIB_LO;
            NIB_LO:  stateNext_s = NIB_HI;
            default: stateNext_s = INIT_A;
         endcase
      end else begin
         stateNext_s = state_r;
      end
   end

   // FSM output decode: error/load strobes and the gap to enforce next
   always_comb begin
      seqErr_s   = 1'b0;
      byteLoad_s = 1'b0;
      hiLoad_s   = 1'b0;
      initSet_s  = 1'b0;
      gapLoad_s  = 21'd0;
      if (strobe_s) begin
         case (state_r)
            INIT_A: begin
               gapLoad_s = GAP_INIT_A;
               seqErr_s  = (dQ_r != 5'b00011);
            end
            INIT_B, INIT_C: begin
               gapLoad_s = GAP_CMD;
               seqErr_s  = (dQ_r != 5'b00011);
            end
            INIT_D: begin
               gapLoad_s = GAP_CMD;
               initSet_s = (dQ_r == 5'b00010);
               seqErr_s  = (dQ_r != 5'b00010);
            end
            NIB_HI: begin
               gapLoad_s = GAP_NIB;
               hiLoad_s  = 1'b1;
            end
            NIB_LO: begin
               gapLoad_s = isSlowCmd(dQ_r[4], formed_s) ? GAP_SLOW : GAP_FAST;
               // An RS change mid-byte means the two nibbles do not belong together
               if (dQ_r[4] != hiRs_r) begin
                  seqErr_s = 1'b1;
               end else begin
                  byteLoad_s = 1'b1;
               end
            end
            default: begin
               gapLoad_s = 21'd0;
            end
         endcase
      end else begin
         gapLoad_s = 21'd0;
      end
   end

   // High-nibble holding register; a reset drops any half-received byte
   always_ff @(posedge CLK) begin
      if (RST) begin
         hiNib_r <= 4'd0;
         hiRs_r  <= 1'b0;
      end else if (hiLoad_s) begin
         hiNib_r <= dQ_r[3:0];
         hiRs_r  <= dQ_r[4];
      end else begin
         hiNib_r <= hiNib_r;
         hiRs_r  <= hiRs_r;
      end
   end

   // Registered outputs, one cycle after the strobe cycle
   always_ff @(posedge CLK) begin
      if (RST) begin
         byte_out   <= 8'd0;
         byte_rs    <= 1'b0;
         byte_valid <= 1'b0;
         init_done  <= 1'b0;
         seq_err    <= 1'b0;
         timing_err <= 1'b0;
         err_count  <= 8'd0;
      end else begin
         byte_valid <= byteLoad_s;
         if (byteLoad_s) begin
            byte_out <= formed_s;
            byte_rs  <= dQ_r[4];
         end else begin
            byte_out <= byte_out;
            byte_rs  <= byte_rs;
         end
         init_done  <= init_done | initSet_s;
         seq_err    <= seqErr_s;
         timing_err <= timErr_s;
         err_count  <= satAdd(err_count, {1'b0, seqErr_s} + {1'b0, timErr_s});
      end
   end

endmodule

// File: doc/lcd_bus_monitor.md
LCD_BUS_MONITOR -- requirements
Module: lcd_bus_monitor

Interface
REQ-001 Parameter FREQ, default 50000000, system clock frequency in Hz; all timing limits derive from T1US = FREQ/1000000.
REQ-002 Parameter T_EH, default 12, minimum LCD_E high width in CLK cycles.
REQ-003 CLK  input  1  system clock; all logic on its rising edge.
REQ-004 RST  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 LCD_D  input  5  observed bus: bit4 = RS, bits[3:0] = data nibble D7..D4.
REQ-006 LCD_E  input  1  observed enable strobe.
REQ-007 byte_out  output  8  last reassembled byte.
REQ-008 byte_rs  output  1  RS of last reassembled byte.
REQ-009 byte_valid  output  1  one-cycle pulse: byte_out/byte_rs updated.
REQ-010 init_done  output  1  level; 4-bit mode entered.
REQ-011 seq_err  output  1  one-cycle pulse; illegal nibble during 8-bit init phase.
REQ-012 timing_err  output  1  one-cycle pulse; strobe violated a minimum-gap or E-width limit.
REQ-013 err_count  output  8  saturating count of seq_err plus timing_err events.

Function
REQ-014 LCD_E and LCD_D shall be registered once (e_q, d_q); a strobe is the cycle where e_q=1 and LCD_E=0; the captured nibble is d_q.
REQ-015 An E-high counter shall count cycles with e_q=1; a strobe with count < T_EH raises timing_err but is still processed.
REQ-016 States: INIT_A, INIT_B, INIT_C, INIT_D (8-bit phase, one strobe per command), NIB_HI, NIB_LO (4-bit mode).
REQ-017 INIT_A/B/C: strobe with nibble 5'b00011 advances to the next state; INIT_D: nibble 5'b00010 goes to NIB_HI and sets init_done.
REQ-018 Any other nibble in INIT_A..INIT_D returns to INIT_A and pulses seq_err.
REQ-019 NIB_HI: strobe stores RS and high nibble, goes to NIB_LO; NIB_LO: strobe forms {high,low}, goes to NIB_HI.
REQ-020 RS differing between high and low nibble shall pulse seq_err, drop the byte, and return to NIB_HI.
REQ-021 byte_out, byte_rs, byte_valid shall update on the clock edge after the completing strobe cycle (latency 1 cycle from strobe detection).
REQ-022 A 21-bit gap counter is loaded on every accepted strobe and decrements to 0; a strobe while it is nonzero pulses timing_err and is still processed.
REQ-023 Gap loads: after INIT_A strobe 4100*T1US; after INIT_B, INIT_C, INIT_D strobes 100*T1US; after high nibble 1*T1US; after low nibble 1520*T1US if RS=0 and byte is 8'h01, 8'h02 or 8'h03, else 37*T1US.
REQ-024 seq_err and timing_err in the same cycle shall increment err_count by 2; err_count saturates at 8'hFF.
REQ-025 Once set, init_done remains set until RST; seq_err in 4-bit mode does not clear it.
REQ-026 Strobes on consecutive cycles are impossible by construction (E must rise between them); no special handling required.

Reset
REQ-027 RST shall force state INIT_A, gap counter 0, E-high counter 0, e_q 0, d_q 0, all outputs 0; mid-byte RST discards a stored high nibble.

Verification
REQ-028 Legal init (00011 after 4.1 ms, 00011, 00011, 00010 at 100 us gaps), then bytes 0x2C, 0x08, 0x01, 0x06, 0x0C (RS=0) and 0x78 (RS=1) at 10 us/53 us/3 ms nibble spacing -> six byte_valid pulses with exactly those values, init_done=1, err_count=0.
REQ-029 Second init strobe 50 us after first -> timing_err pulse, err_count=1, state still advances to INIT_C.
REQ-030 Nibble 00010 received in INIT_A -> seq_err pulse, state INIT_A, init_done=0.
REQ-031 Byte 0x01 followed by next high nibble 1 ms later -> timing_err; same after 0x0C at 40 us -> no error.
REQ-032 High nibble RS=1, low nibble RS=0 -> seq_err, no byte_valid; next full byte decoded normally.
REQ-033 RST asserted between high and low nibble -> outputs 0, state INIT_A; the following low nibble 00011 is treated as first init strobe.
